cluster_icache_ctrl_perfctr_reg_top: RTL and testbench
======================================================

CLUSTER_ICACHE_CTRL_PERFCTR_REG_TOP -- requirements
Module: cluster_icache_ctrl_perfctr_reg_top

Interface
REQ-001 SHALL have parameter reg_req_t, default logic, register request struct with fields valid, write, addr[31:0], wdata[31:0], wstrb[3:0].
REQ-002 SHALL have parameter reg_rsp_t, default logic, response struct with fields ready, error, rdata[31:0].
REQ-003 SHALL have port clk_i, input, 1, sole clock; all state updates on rising edge.
REQ-004 SHALL have port rst_i, input, 1, synchronous active-high reset.
REQ-005 SHALL have port reg_req_i, input, reg_req_t, software access request.
REQ-006 SHALL have port reg_rsp_o, output, reg_rsp_t, software access response.
REQ-007 SHALL have port reg2hw, output, cluster_icache_ctrl_perfctr_reg2hw_t, register values and strobes to hardware.
REQ-008 SHALL have port hw2reg, input, cluster_icache_ctrl_perfctr_hw2reg_t, hardware status and counter updates.
REQ-009 SHALL have port devmode_i, input, 1, accepted and ignored.

Function
REQ-010 Register map (word offsets, 32-bit): 0x00 ENABLE_COUNTERS[0] RW; 0x04 ENABLE_PREFETCH[0] RW; 0x08 FLUSH[0]; 0x0C FLUSH_L1_ONLY[0]; 0x10 SEL_FLUSH_ICACHE[NumCores-1:0]; 0x14 CLEAR_COUNTERS[0]; 0x100+4*i COUNTERS[i][31:0] for i in 0..NumAvailableCounters-1.
REQ-011 Access completes same cycle: reg_rsp_o.ready = 1 always; rdata/error combinational from addr when valid; rdata = 0 when not valid or on error.
REQ-012 Write strobe = valid & write & mapped addr; read strobe = valid & ~write & mapped addr.
REQ-013 Unmapped address (including unaligned addr[1:0] != 0) SHALL give error = 1, no state change, rdata = 0.
REQ-014 Unused bits read as 0; writes to them ignored.
REQ-015 ENABLE_COUNTERS, ENABLE_PREFETCH: flop-backed; write takes effect next cycle on reg2hw.<reg>.q.
REQ-016 FLUSH, FLUSH_L1_ONLY, SEL_FLUSH_ICACHE, CLEAR_COUNTERS are hardware-external: no storage; reg2hw.<reg>.q = wdata field when that register's write strobe is high, else 0; reg2hw.<reg>.qe = write strobe (combinational 1-cycle pulse).
REQ-017 Reads of external registers return hw2reg.<reg>.d.
REQ-018 COUNTERS[i]: 32-bit flop; next = wdata on SW write, else hw2reg.counters[i].d when hw2reg.counters[i].de, else hold; SW write wins over simultaneous de.
REQ-019 reg2hw.counters[i].q = counter flop; read returns flop value; no internal increment or wrap logic (hardware supplies d, wraps naturally at 32 bits).

Reset
REQ-020 On rst_i: ENABLE_COUNTERS = 0, ENABLE_PREFETCH = 1, all COUNTERS = 0; external q/qe outputs remain combinational (0 without a write).
REQ-021 Access during reset cycle: response still generated; writes in that cycle are discarded (reset wins).

Configuration
REQ-022 Macro CLUSTER_ICACHE_PERFCTR_WSTRB_CHECK_EN: when defined, a write with wstrb != 4'hF to any mapped register SHALL return error = 1 and cause no state change and no qe pulse; when undefined, wstrb is ignored and every write is full-word.

Structure
REQ-023 Package cluster_icache_ctrl_perfctr_reg_pkg SHALL hold NumCores = 8, NumL1Events = 7, NumL0Events = 5, NumAvailableCounters = 47, register offsets, and reg2hw/hw2reg struct types including cluster_icache_ctrl_perfctr_hw2reg_counters_mreg_t {d[31:0], de}.
REQ-024 One sub-module cluster_icache_ctrl_perfctr_subreg (parameterised width, reset value, SW/HW write priority) SHALL implement every flop-backed field.

Verification
REQ-025 After reset, read 0x04 -> rdata 1, read 0x00 -> 0, read 0x100 -> 0, error 0.
REQ-026 Write 0x14 wdata 1 -> reg2hw.clear_counters.q = 1 and qe = 1 that cycle only; next cycle both 0.
REQ-027 Write 0x10 wdata 0x05 -> sel_flush_icache.q = 0x05, qe pulse; hw2reg.sel_flush_icache.d = 0xA0 -> read 0x10 returns 0xA0.
REQ-028 Counter 3: de = 1, d = 0x10 -> read 0x10C = 0x10; same cycle SW writes 0x55 with de = 1 -> value 0x55.
REQ-029 Read 0x18 -> error 1, rdata 0; write 0x200 -> error 1, no register changes.
REQ-030 With CLUSTER_ICACHE_PERFCTR_WSTRB_CHECK_EN, write 0x00 wstrb 4'h1 -> error 1, ENABLE_COUNTERS unchanged.

Source files
------------

// File: rtl/cluster_icache_ctrl_perfctr_reg_pkg.sv
// Register-file types and address map for the cluster icache controller and its performance counters.
package cluster_icache_ctrl_perfctr_reg_pkg;

  localparam int NumCores             = 8;
  localparam int NumL1Events          = 7;
  localparam int NumL0Events          = 5;
  // One L0 event set per core plus the shared L1 events.
  localparam int NumAvailableCounters = NumCores * NumL0Events + NumL1Events;

  localparam logic [31:0] ENABLE_COUNTERS_OFFSET  = 32'h000;
  localparam logic [31:0] ENABLE_PREFETCH_OFFSET  = 32'h004;
  localparam logic [31:0] FLUSH_OFFSET            = 32'h008;
  localparam logic [31:0] FLUSH_L1_ONLY_OFFSET    = 32'h00C;
  localparam logic [31:0] SEL_FLUSH_ICACHE_OFFSET = 32'h010;
  localparam logic [31:0] CLEAR_COUNTERS_OFFSET   = 32'h014;
  localparam logic [31:0] COUNTERS_OFFSET         = 32'h100;
  localparam logic [31:0] COUNTERS_END            = 32'(COUNTERS_OFFSET + 4 * NumAvailableCounters);

  typedef struct packed {
    logic        valid;
    logic        write;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } perfctr_reg_req_t;

  typedef struct packed {
    logic        ready;
    logic        error;
    logic [31:0] rdata;
  } perfctr_reg_rsp_t;

  typedef struct packed { logic q; } reg2hw_flag_t;
  typedef struct packed { logic q; logic qe; } reg2hw_ext_flag_t;
  typedef struct packed { logic [NumCores-1:0] q; logic qe; } reg2hw_sel_flush_t;
  typedef struct packed { logic [31:0] q; } reg2hw_counters_mreg_t;

  typedef struct packed {
    reg2hw_flag_t                                     enable_counters;
    reg2hw_flag_t                                     enable_prefetch;
    reg2hw_ext_flag_t                                 flush;
    reg2hw_ext_flag_t                                 flush_l1_only;
    reg2hw_sel_flush_t                                sel_flush_icache;
    reg2hw_ext_flag_t                                 clear_counters;
    reg2hw_counters_mreg_t [NumAvailableCounters-1:0] counters;
  } cluster_icache_ctrl_perfctr_reg2hw_t;

  typedef struct packed { logic d; } hw2reg_flag_t;
  typedef struct packed { logic [NumCores-1:0] d; } hw2reg_sel_flush_t;
  typedef struct packed { logic [31:0] d; logic de; } cluster_icache_ctrl_perfctr_hw2reg_counters_mreg_t;

  typedef struct packed {
    hw2reg_flag_t                                                          flush;
    hw2reg_flag_t                                                          flush_l1_only;
    hw2reg_sel_flush_t                                                     sel_flush_icache;
    hw2reg_flag_t                                                          clear_counters;
    cluster_icache_ctrl_perfctr_hw2reg_counters_mreg_t [NumAvailableCounters-1:0] counters;
  } cluster_icache_ctrl_perfctr_hw2reg_t;

endpackage

// File: rtl/cluster_icache_ctrl_perfctr_reg_top_subreg.sv
// Flop-backed register field with software write port and hardware data-enable port.
module cluster_icache_ctrl_perfctr_subreg
  import cluster_icache_ctrl_perfctr_reg_pkg::*;
#(
  parameter int               WIDTH   = 32,
  parameter logic [WIDTH-1:0] RESVAL  = '0,
  parameter bit               SW_PRIO = 1'b1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             we,
  input  logic [WIDTH-1:0] wd,
  input  logic             de,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      q <= RESVAL;
    end else if (SW_PRIO) begin
      if (we)      q <= wd;
      else if (de) q <= d;
    end else begin
      if (de)      q <= d;
      else if (we) q <= wd;
    end
  end

endmodule

// File: rtl/cluster_icache_ctrl_perfctr_reg_top.sv
// Register file for icache control and perf counters; single-cycle access, errors on unmapped addresses.
// Define CLUSTER_ICACHE_PERFCTR_WSTRB_CHECK_EN to reject partial-strobe writes with an error.
module cluster_icache_ctrl_perfctr_reg_top
  import cluster_icache_ctrl_perfctr_reg_pkg::*;
#(
  parameter type reg_req_t = perfctr_reg_req_t,
  parameter type reg_rsp_t = perfctr_reg_rsp_t
) (
  input  logic                                clk_i,
  input  logic                                rst_i,
  input  reg_req_t                            reg_req_i,
  output reg_rsp_t                            reg_rsp_o,
  output cluster_icache_ctrl_perfctr_reg2hw_t reg2hw,
  input  cluster_icache_ctrl_perfctr_hw2reg_t hw2reg,
  input  logic                                devmode_i
);

  localparam int CntIdxW = $clog2(NumAvailableCounters);

  logic [31:0]               addr;
  logic [31:0]               cnt_off;
  logic                      aligned;
  logic                      hit_en_cnt, hit_en_pf, hit_flush, hit_flush_l1, hit_sel, hit_clr, hit_cnt;
  logic                      addr_hit, wstrb_err, access_ok, we;
  logic [CntIdxW-1:0]        cnt_idx;
  logic                      en_cnt_q, en_pf_q;
  logic [NumAvailableCounters-1:0] cnt_we;
  logic [31:0]               cnt_q [NumAvailableCounters];
  logic [31:0]               cnt_rd;
  logic [31:0]               rdata;
  logic                      unused_sink;

  assign addr         = reg_req_i.addr;
  assign aligned      = (addr[1:0] == 2'b00);
  assign hit_en_cnt   = (addr == ENABLE_COUNTERS_OFFSET);
  assign hit_en_pf    = (addr == ENABLE_PREFETCH_OFFSET);
  assign hit_flush    = (addr == FLUSH_OFFSET);
  assign hit_flush_l1 = (addr == FLUSH_L1_ONLY_OFFSET);
  assign hit_sel      = (addr == SEL_FLUSH_ICACHE_OFFSET);
  assign hit_clr      = (addr == CLEAR_COUNTERS_OFFSET);
  assign cnt_off      = addr - COUNTERS_OFFSET;
  assign hit_cnt      = aligned && (addr >= COUNTERS_OFFSET) && (addr < COUNTERS_END);
  assign cnt_idx      = cnt_off[CntIdxW+1:2];
  assign addr_hit     = hit_en_cnt | hit_en_pf | hit_flush | hit_flush_l1 | hit_sel | hit_clr | hit_cnt;

`ifdef CLUSTER_ICACHE_PERFCTR_WSTRB_CHECK_EN
  assign wstrb_err = reg_req_i.write && (reg_req_i.wstrb != 4'hF);
`else
  assign wstrb_err = 1'b0;
`endif

  assign access_ok = reg_req_i.valid && addr_hit && !wstrb_err;
  assign we        = access_ok && reg_req_i.write;

  // devmode and the strobe lanes carry no function in the default build.
  assign unused_sink = ^{devmode_i, reg_req_i.wstrb, cnt_off[31:CntIdxW+2], cnt_off[1:0]};

  always_comb begin
    cnt_we = '0;
    cnt_rd = '0;
    for (int i = 0; i < NumAvailableCounters; i++) begin
      if (hit_cnt && (cnt_idx == CntIdxW'(i))) begin
        cnt_we[i] = we;
        cnt_rd    = cnt_q[i];
      end
    end
  end

  cluster_icache_ctrl_perfctr_subreg #(.WIDTH(1), .RESVAL(1'b0), .SW_PRIO(1'b1)) u_enable_counters (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .we    (we && hit_en_cnt),
    .wd    (reg_req_i.wdata[0]),
    .de    (1'b0),
    .d     (1'b0),
    .q     (en_cnt_q)
  );

  cluster_icache_ctrl_perfctr_subreg #(.WIDTH(1), .RESVAL(1'b1), .SW_PRIO(1'b1)) u_enable_prefetch (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .we    (we && hit_en_pf),
    .wd    (reg_req_i.wdata[0]),
    .de    (1'b0),
    .d     (1'b0),
    .q     (en_pf_q)
  );

  for (genvar g = 0; g < NumAvailableCounters; g++) begin : g_counters
    cluster_icache_ctrl_perfctr_subreg #(.WIDTH(32), .RESVAL(32'h0), .SW_PRIO(1'b1)) u_counter (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .we    (cnt_we[g]),
      .wd    (reg_req_i.wdata),
      .de    (hw2reg.counters[g].de),
      .d     (hw2reg.counters[g].d),
      .q     (cnt_q[g])
    );
  end

  always_comb begin
    rdata = '0;
    if (access_ok) begin
      if (hit_en_cnt)        rdata[0]          = en_cnt_q;
      else if (hit_en_pf)    rdata[0]          = en_pf_q;
      else if (hit_flush)    rdata[0]          = hw2reg.flush.d;
      else if (hit_flush_l1) rdata[0]          = hw2reg.flush_l1_only.d;
      else if (hit_sel)      rdata[NumCores-1:0] = hw2reg.sel_flush_icache.d;
      else if (hit_clr)      rdata[0]          = hw2reg.clear_counters.d;
      else                   rdata             = cnt_rd;
    end
  end

  always_comb begin
    reg_rsp_o       = '0;
    reg_rsp_o.ready = 1'b1;
    reg_rsp_o.error = reg_req_i.valid && !access_ok;
    reg_rsp_o.rdata = rdata;
  end

  // External registers have no storage: q mirrors wdata only while the write strobe is up.
  always_comb begin
    reg2hw                        = '0;
    reg2hw.enable_counters.q      = en_cnt_q;
    reg2hw.enable_prefetch.q      = en_pf_q;
    reg2hw.flush.qe               = we && hit_flush;
    reg2hw.flush.q                = we && hit_flush && reg_req_i.wdata[0];
    reg2hw.flush_l1_only.qe       = we && hit_flush_l1;
    reg2hw.flush_l1_only.q        = we && hit_flush_l1 && reg_req_i.wdata[0];
    reg2hw.sel_flush_icache.qe    = we && hit_sel;
    reg2hw.sel_flush_icache.q     = (we && hit_sel) ? reg_req_i.wdata[NumCores-1:0] : '0;
    reg2hw.clear_counters.qe      = we && hit_clr;
    reg2hw.clear_counters.q       = we && hit_clr && reg_req_i.wdata[0];
    for (int i = 0; i < NumAvailableCounters; i++) begin
      reg2hw.counters[i].q = cnt_q[i];
    end
  end

endmodule

// File: tb/tb_cluster_icache_ctrl_perfctr_reg_top.sv
// Scoreboard bench: stimulus queues expected responses, a negedge monitor pops and compares them.
module tb_cluster_icache_ctrl_perfctr_reg_top;
  import cluster_icache_ctrl_perfctr_reg_pkg::*;

  logic                                clk = 1'b0;
  logic                                rst;
  perfctr_reg_req_t                    req;
  perfctr_reg_rsp_t                    rsp;
  cluster_icache_ctrl_perfctr_reg2hw_t reg2hw;
  cluster_icache_ctrl_perfctr_hw2reg_t hw2reg;
  logic                                devmode;

  cluster_icache_ctrl_perfctr_reg_top #(
    .reg_req_t (perfctr_reg_req_t),
    .reg_rsp_t (perfctr_reg_rsp_t)
  ) u_dut (
    .clk_i     (clk),
    .rst_i     (rst),
    .reg_req_i (req),
    .reg_rsp_o (rsp),
    .reg2hw    (reg2hw),
    .hw2reg    (hw2reg),
    .devmode_i (devmode)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          side;
    logic [31:0] side_val;
    string       name;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // side: 1 clear_counters {q,qe}; 2 sel_flush_icache {q,qe}; 3 enable_counters.q; 4 enable_prefetch.q
  function automatic logic [31:0] side_act(int side);
    case (side)
      1:       return {30'b0, reg2hw.clear_counters.q, reg2hw.clear_counters.qe};
      2:       return {23'b0, reg2hw.sel_flush_icache.q, reg2hw.sel_flush_icache.qe};
      3:       return {31'b0, reg2hw.enable_counters.q};
      4:       return {31'b0, reg2hw.enable_prefetch.q};
      default: return 32'h0;
    endcase
  endfunction

  always @(negedge clk) begin
    if (req.valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_rsp: response with no expectation queued, addr=%h", req.addr);
      end else begin
        exp_t e;
        logic [31:0] sa;
        e = exp_q.pop_front();
        checks++;
        if (rsp.rdata !== e.rdata || rsp.error !== e.err || rsp.ready !== 1'b1) begin
          errors++;
          $display("FAIL %s: got rdata=%h error=%b ready=%b, want rdata=%h error=%b ready=1",
                   e.name, rsp.rdata, rsp.error, rsp.ready, e.rdata, e.err);
        end
        if (e.side != 0) begin
          checks++;
          sa = side_act(e.side);
          if (sa !== e.side_val) begin
            errors++;
            $display("FAIL %s_hw: got %h, want %h", e.name, sa, e.side_val);
          end
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    req.valid = 1'b0;
  endtask

  task automatic issue(input logic wr, input logic [31:0] a, input logic [31:0] wd, input logic [3:0] st,
                       input logic [31:0] exp_rd, input logic exp_err, input int side,
                       input logic [31:0] side_val, input string name);
    exp_t e;
    req.valid  = 1'b1;
    req.write  = wr;
    req.addr   = a;
    req.wdata  = wd;
    req.wstrb  = st;
    e.rdata    = exp_rd;
    e.err      = exp_err;
    e.side     = side;
    e.side_val = side_val;
    e.name     = name;
    exp_q.push_back(e);
  endtask

  task automatic rd(input logic [31:0] a, input logic [31:0] exp_rd, input logic exp_err, input string name);
    step();
    issue(1'b0, a, 32'h0, 4'hF, exp_rd, exp_err, 0, 32'h0, name);
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] wd, input logic [31:0] exp_rd,
                    input logic exp_err, input string name);
    step();
    issue(1'b1, a, wd, 4'hF, exp_rd, exp_err, 0, 32'h0, name);
  endtask

  initial begin
    rst     = 1'b1;
    req     = '0;
    hw2reg  = '0;
    devmode = 1'b0;
    repeat (2) @(posedge clk);

    step(); issue(1'b1, 32'h00, 32'h1, 4'hF, 32'h0, 1'b0, 0, 32'h0, "wr_during_reset");
    step(); rst = 1'b0;

    rd(32'h04, 32'h1, 1'b0, "rst_prefetch");
    rd(32'h00, 32'h0, 1'b0, "rst_en_cnt");
    rd(32'h100, 32'h0, 1'b0, "rst_cnt0");

    step(); issue(1'b1, 32'h14, 32'h1, 4'hF, 32'h0, 1'b0, 1, 32'h3, "clr_pulse");
    step(); issue(1'b0, 32'h00, 32'h0, 4'hF, 32'h0, 1'b0, 1, 32'h0, "clr_after");
    step(); issue(1'b1, 32'h10, 32'h5, 4'hF, 32'h0, 1'b0, 2, 32'h0B, "sel_pulse");
    step(); hw2reg.sel_flush_icache.d = 8'hA0;
            issue(1'b0, 32'h10, 32'h0, 4'hF, 32'hA0, 1'b0, 2, 32'h0, "sel_read_hw");
    step(); hw2reg.flush.d = 1'b1; hw2reg.clear_counters.d = 1'b1;
            issue(1'b0, 32'h08, 32'h0, 4'hF, 32'h1, 1'b0, 0, 32'h0, "flush_read_hw");
    rd(32'h0C, 32'h0, 1'b0, "flush_l1_read_hw");
    rd(32'h14, 32'h1, 1'b0, "clr_read_hw");

    step(); hw2reg.counters[3].de = 1'b1; hw2reg.counters[3].d = 32'h10;
    step(); hw2reg.counters[3].de = 1'b0;
            issue(1'b0, 32'h10C, 32'h0, 4'hF, 32'h10, 1'b0, 0, 32'h0, "cnt3_hw_load");
    step(); hw2reg.counters[3].de = 1'b1; hw2reg.counters[3].d = 32'h99;
            issue(1'b1, 32'h10C, 32'h55, 4'hF, 32'h10, 1'b0, 0, 32'h0, "cnt3_sw_vs_hw");
    step(); hw2reg.counters[3].de = 1'b0;
            issue(1'b0, 32'h10C, 32'h0, 4'hF, 32'h55, 1'b0, 0, 32'h0, "cnt3_sw_wins");
    rd(32'h108, 32'h0, 1'b0, "cnt2_untouched");

    rd(32'h18, 32'h0, 1'b1, "unmapped_rd");
    wr(32'h200, 32'hFFFF_FFFF, 32'h0, 1'b1, "unmapped_wr");
    rd(32'h00, 32'h0, 1'b0, "en_cnt_untouched");
    rd(32'h04, 32'h1, 1'b0, "pf_untouched");
    rd(32'h102, 32'h0, 1'b1, "unaligned_rd");

    wr(32'h00, 32'h1, 32'h0, 1'b0, "en_cnt_set");
    step(); issue(1'b0, 32'h00, 32'h0, 4'hF, 32'h1, 1'b0, 3, 32'h1, "en_cnt_q");
    wr(32'h04, 32'hFFFF_FFFE, 32'h1, 1'b0, "pf_clear");
    step(); issue(1'b0, 32'h04, 32'h0, 4'hF, 32'h0, 1'b0, 4, 32'h0, "pf_cleared");

    wr(32'h1B8, 32'hDEAD_BEEF, 32'h0, 1'b0, "cnt46_wr");
    rd(32'h1B8, 32'hDEAD_BEEF, 1'b0, "cnt46_rd");
    rd(32'h1BC, 32'h0, 1'b1, "past_last_cnt");

`ifdef CLUSTER_ICACHE_PERFCTR_WSTRB_CHECK_EN
    step(); issue(1'b1, 32'h00, 32'h0, 4'h1, 32'h0, 1'b1, 0, 32'h0, "wstrb_err");
    rd(32'h00, 32'h1, 1'b0, "wstrb_no_change");
    step(); issue(1'b1, 32'h14, 32'h1, 4'h3, 32'h0, 1'b1, 1, 32'h0, "wstrb_no_qe");
`else
    step(); issue(1'b1, 32'h00, 32'h0, 4'h1, 32'h1, 1'b0, 0, 32'h0, "wstrb_ignored");
    rd(32'h00, 32'h0, 1'b0, "wstrb_full_word");
`endif

    step(); rst = 1'b1;
    step(); rst = 1'b0;
    rd(32'h10C, 32'h0, 1'b0, "cnt3_reset");
    rd(32'h1B8, 32'h0, 1'b0, "cnt46_reset");
    rd(32'h04, 32'h1, 1'b0, "pf_reset");

    step();
    repeat (2) @(posedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
